// File: rtl/tk_pkg.sv
// Shared field moduli, widths and the count-direction encoding for the
// time-keeping datapath.
package tk_pkg;

  localparam int CSEC_MOD = 100;
  localparam int SEC_MOD  = 60;
  localparam int MIN_MOD  = 60;

  localparam int CSEC_W   = 7;
  localparam int SEC_W    = 6;
  localparam int MIN_W    = 6;

  typedef enum logic {
    TK_UP   = 1'b0,
    TK_DOWN = 1'b1
  } tk_mode_e;

endpackage

// File: rtl/tk_field_counter.sv
// One modulo-MOD time field. Carry/borrow out is combinational so that a
// chain of these updates every field on the same clock edge.
module tk_field_counter
  import tk_pkg::*;
#(
  parameter int MOD = 60,
  parameter int W   = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         dir,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         clr,
  output logic [W-1:0] val,
  output logic         co
);

  logic [W-1:0] r_val;
  logic         w_at_max;
  logic         w_at_min;
  logic [W-1:0] w_next;

  function automatic logic [W-1:0] sat_mod(input logic [W-1:0] v);
    if (int'(v) >= MOD) return W'(MOD - 1);
    return v;
  endfunction

  assign w_at_max = (r_val == W'(MOD - 1));
  assign w_at_min = (r_val == '0);

  always_comb begin
    w_next = r_val;
    if (dir == TK_DOWN) w_next = w_at_min ? W'(MOD - 1) : r_val - W'(1);
    else                w_next = w_at_max ? '0          : r_val + W'(1);
  end

  assign co = en & ((dir == TK_DOWN) ? w_at_min : w_at_max);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     r_val <= '0;
    else if (clr)  r_val <= '0;
    else if (load) r_val <= sat_mod(load_val);
    else if (en)   r_val <= w_next;
  end

  assign val = r_val;

endmodule

// File: rtl/time_keeper_dp.sv
// Up/down stopwatch/timer datapath: tick divider, four cascaded time fields,
// lap snapshot, rollover pulse and sticky countdown-done flag.
module time_keeper_dp
  import tk_pkg::*;
#(
  parameter int  CLK_HZ   = 100_000_000,
  parameter int  TICK_HZ  = 100,
  parameter int  HOUR_MAX = 24,
  localparam int HW       = $clog2(HOUR_MAX)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              clear,
  input  logic              mode,
  input  logic              load,
  input  logic [CSEC_W-1:0] pre_csec,
  input  logic [SEC_W-1:0]  pre_sec,
  input  logic [MIN_W-1:0]  pre_min,
  input  logic [HW-1:0]     pre_hour,
  input  logic              lap,
  output logic [CSEC_W-1:0] csec,
  output logic [SEC_W-1:0]  sec,
  output logic [MIN_W-1:0]  min,
  output logic [HW-1:0]     hour,
  output logic [CSEC_W-1:0] lap_csec,
  output logic [SEC_W-1:0]  lap_sec,
  output logic [MIN_W-1:0]  lap_min,
  output logic [HW-1:0]     lap_hour,
  output logic              lap_valid,
  output logic              wrap,
  output logic              done
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int DW  = (DIV > 2) ? $clog2(DIV) : 1;

  logic [DW-1:0]     r_div;
  logic              r_done;
  logic              r_wrap;
  logic              r_lap_valid;
  logic [CSEC_W-1:0] r_lap_csec;
  logic [SEC_W-1:0]  r_lap_sec;
  logic [MIN_W-1:0]  r_lap_min;
  logic [HW-1:0]     r_lap_hour;

  logic [CSEC_W-1:0] w_csec;
  logic [SEC_W-1:0]  w_sec;
  logic [MIN_W-1:0]  w_min;
  logic [HW-1:0]     w_hour;
  logic              w_co_csec, w_co_sec, w_co_min, w_co_hour;
  logic              w_down, w_zero, w_one, w_halt;
  logic              w_div_last, w_tick, w_adv;

  assign w_down     = (mode == TK_DOWN);
  assign w_zero     = (w_csec == '0) && (w_sec == '0) && (w_min == '0) && (w_hour == '0);
  assign w_one      = (w_csec == CSEC_W'(1)) && (w_sec == '0) && (w_min == '0) && (w_hour == '0);
  // A countdown parked at zero must not borrow, so the divider freezes there.
  assign w_halt     = w_down & (r_done | w_zero);
  assign w_div_last = (r_div == DW'(DIV - 1));
  assign w_tick     = run & ~w_halt & w_div_last;
  assign w_adv      = w_tick & ~clear & ~load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                r_div <= '0;
    else if (clear || load)   r_div <= '0;
    else if (run && !w_halt)  r_div <= w_div_last ? '0 : r_div + DW'(1);
  end

  tk_field_counter #(.MOD(CSEC_MOD), .W(CSEC_W)) u_csec (
    .clk(clk), .reset(reset), .en(w_adv), .dir(mode), .load(load),
    .load_val(pre_csec), .clr(clear), .val(w_csec), .co(w_co_csec)
  );

  tk_field_counter #(.MOD(SEC_MOD), .W(SEC_W)) u_sec (
    .clk(clk), .reset(reset), .en(w_co_csec), .dir(mode), .load(load),
    .load_val(pre_sec), .clr(clear), .val(w_sec), .co(w_co_sec)
  );

  tk_field_counter #(.MOD(MIN_MOD), .W(MIN_W)) u_min (
    .clk(clk), .reset(reset), .en(w_co_sec), .dir(mode), .load(load),
    .load_val(pre_min), .clr(clear), .val(w_min), .co(w_co_min)
  );

  tk_field_counter #(.MOD(HOUR_MAX), .W(HW)) u_hour (
    .clk(clk), .reset(reset), .en(w_co_min), .dir(mode), .load(load),
    .load_val(pre_hour), .clr(clear), .val(w_hour), .co(w_co_hour)
  );

  // Carry out of the hour field in up mode is exactly the all-max rollover.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      r_wrap <= 1'b0;
    else if (clear) r_wrap <= 1'b0;
    else            r_wrap <= ~w_down & w_co_hour;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      r_done <= 1'b0;
    else if (clear || load)         r_done <= 1'b0;
    else if (w_adv && w_down && w_one) r_done <= 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset || clear) begin
      r_lap_valid <= 1'b0;
      r_lap_csec  <= '0;
      r_lap_sec   <= '0;
      r_lap_min   <= '0;
      r_lap_hour  <= '0;
    end else if (lap) begin
      r_lap_valid <= 1'b1;
      r_lap_csec  <= w_csec;
      r_lap_sec   <= w_sec;
      r_lap_min   <= w_min;
      r_lap_hour  <= w_hour;
    end
  end

  assign csec      = w_csec;
  assign sec       = w_sec;
  assign min       = w_min;
  assign hour      = w_hour;
  assign lap_csec  = r_lap_csec;
  assign lap_sec   = r_lap_sec;
  assign lap_min   = r_lap_min;
  assign lap_hour  = r_lap_hour;
  assign lap_valid = r_lap_valid;
  assign wrap      = r_wrap;
  assign done      = r_done;

endmodule

// File: tb/tb_time_keeper_dp.sv
// Scoreboard bench for time_keeper_dp at DIV=10, HOUR_MAX=24.
module tb_time_keeper_dp;

  localparam int HW = 5;
  localparam int K_TIME = 0;
  localparam int K_LAP  = 1;
  localparam int K_FLAG = 2;

  logic          clk = 1'b0;
  logic          reset, run, clear, mode, load, lap;
  logic [6:0]    pre_csec;
  logic [5:0]    pre_sec, pre_min;
  logic [HW-1:0] pre_hour;
  logic [6:0]    csec, lap_csec;
  logic [5:0]    sec, min, lap_sec, lap_min;
  logic [HW-1:0] hour, lap_hour;
  logic          lap_valid, wrap, done;

  time_keeper_dp #(.CLK_HZ(1000), .TICK_HZ(100), .HOUR_MAX(24)) dut (
    .clk(clk), .reset(reset), .run(run), .clear(clear), .mode(mode),
    .load(load), .pre_csec(pre_csec), .pre_sec(pre_sec), .pre_min(pre_min),
    .pre_hour(pre_hour), .lap(lap), .csec(csec), .sec(sec), .min(min),
    .hour(hour), .lap_csec(lap_csec), .lap_sec(lap_sec), .lap_min(lap_min),
    .lap_hour(lap_hour), .lap_valid(lap_valid), .wrap(wrap), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    int          kind;
    logic [63:0] exp;
  } sb_t;
  sb_t sbq[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] tp(input int h, input int m, input int s, input int c);
    return {32'd0, 8'(h), 8'(m), 8'(s), 8'(c)};
  endfunction

  function automatic logic [63:0] fl(input logic lv, input logic wr, input logic dn);
    return {61'd0, lv, wr, dn};
  endfunction

  function automatic logic [63:0] observe(input int kind);
    case (kind)
      K_TIME:  return {32'd0, 8'(hour), 8'(min), 8'(sec), 8'(csec)};
      K_LAP:   return {32'd0, 8'(lap_hour), 8'(lap_min), 8'(lap_sec), 8'(lap_csec)};
      default: return {61'd0, lap_valid, wrap, done};
    endcase
  endfunction

  task automatic expect_val(input string tag, input int kind, input logic [63:0] v);
    sbq.push_back('{tag, kind, v});
  endtask

  task automatic sample();
    sb_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk(e.tag, observe(e.kind), e.exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int h, input int m, input int s, input int c);
    pre_hour = HW'(h);
    pre_min  = 6'(m);
    pre_sec  = 6'(s);
    pre_csec = 7'(c);
    load = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; clear = 1'b0; mode = 1'b0; load = 1'b0; lap = 1'b0;
    pre_csec = '0; pre_sec = '0; pre_min = '0; pre_hour = '0;
    step(2);
    expect_val("rst_time", K_TIME, tp(0, 0, 0, 0));
    expect_val("rst_lap",  K_LAP,  tp(0, 0, 0, 0));
    expect_val("rst_flag", K_FLAG, fl(0, 0, 0));
    sample();

    // Up count from reset: first tick on the 10th edge, 1000 cycles = 1 s.
    reset = 1'b0;
    run   = 1'b1;
    step(9);
    expect_val("up_pre_tick", K_TIME, tp(0, 0, 0, 0));
    sample();
    step(1);
    expect_val("up_first_tick", K_TIME, tp(0, 0, 0, 1));
    sample();
    step(990);
    expect_val("up_1s", K_TIME, tp(0, 0, 1, 0));
    sample();

    // Full rollover.
    do_load(23, 59, 59, 99);
    expect_val("wrap_loaded", K_TIME, tp(23, 59, 59, 99));
    expect_val("wrap_flag0",  K_FLAG, fl(0, 0, 0));
    sample();
    step(9);
    expect_val("wrap_hold", K_TIME, tp(23, 59, 59, 99));
    sample();
    step(1);
    expect_val("wrap_zero", K_TIME, tp(0, 0, 0, 0));
    expect_val("wrap_pulse", K_FLAG, fl(0, 1, 0));
    sample();
    step(1);
    expect_val("wrap_once", K_FLAG, fl(0, 0, 0));
    expect_val("wrap_after", K_TIME, tp(0, 0, 0, 0));
    sample();

    // Out-of-range presets saturate.
    run = 1'b0;
    do_load(31, 63, 63, 127);
    expect_val("sat_load", K_TIME, tp(23, 59, 59, 99));
    sample();

    // Down mode borrow across every field.
    mode = 1'b1;
    run  = 1'b1;
    do_load(1, 0, 0, 0);
    step(10);
    expect_val("borrow_all", K_TIME, tp(0, 59, 59, 99));
    sample();

    // Countdown to zero, done, halt, reload.
    do_load(0, 0, 1, 2);
    step(1019);
    expect_val("cd_last", K_TIME, tp(0, 0, 0, 1));
    expect_val("cd_last_flag", K_FLAG, fl(0, 0, 0));
    sample();
    step(1);
    expect_val("cd_zero", K_TIME, tp(0, 0, 0, 0));
    expect_val("cd_done", K_FLAG, fl(0, 0, 1));
    sample();
    step(500);
    expect_val("cd_held", K_TIME, tp(0, 0, 0, 0));
    expect_val("cd_done_sticky", K_FLAG, fl(0, 0, 1));
    sample();
    do_load(0, 0, 0, 5);
    expect_val("cd_reload", K_TIME, tp(0, 0, 0, 5));
    expect_val("cd_done_clr", K_FLAG, fl(0, 0, 0));
    sample();

    // Zero preset in down mode halts without setting done; up mode releases it.
    do_load(0, 0, 0, 0);
    step(30);
    expect_val("zero_halt", K_TIME, tp(0, 0, 0, 0));
    expect_val("zero_nodone", K_FLAG, fl(0, 0, 0));
    sample();
    mode = 1'b0;
    step(9);
    expect_val("release_hold", K_TIME, tp(0, 0, 0, 0));
    sample();
    step(1);
    expect_val("release_tick", K_TIME, tp(0, 0, 0, 1));
    sample();

    // Pause keeps the sub-tick phase.
    do_load(0, 0, 0, 0);
    step(4);
    run = 1'b0;
    step(37);
    run = 1'b1;
    step(5);
    expect_val("pause_hold", K_TIME, tp(0, 0, 0, 0));
    sample();
    step(1);
    expect_val("pause_tick", K_TIME, tp(0, 0, 0, 1));
    sample();

    // Lap coinciding with a tick captures the pre-tick value.
    do_load(0, 0, 5, 49);
    step(9);
    lap = 1'b1;
    step(1);
    lap = 1'b0;
    expect_val("lap_live", K_TIME, tp(0, 0, 5, 50));
    expect_val("lap_snap", K_LAP,  tp(0, 0, 5, 49));
    expect_val("lap_flag", K_FLAG, fl(1, 0, 0));
    sample();

    // clear beats load and lap.
    pre_hour = 5'd1; pre_min = 6'd2; pre_sec = 6'd3; pre_csec = 7'd4;
    clear = 1'b1; load = 1'b1; lap = 1'b1;
    step(1);
    clear = 1'b0; load = 1'b0; lap = 1'b0;
    expect_val("clr_time", K_TIME, tp(0, 0, 0, 0));
    expect_val("clr_lap",  K_LAP,  tp(0, 0, 0, 0));
    expect_val("clr_flag", K_FLAG, fl(0, 0, 0));
    sample();

    // Async reset mid-count.
    do_load(0, 0, 3, 0);
    lap = 1'b1;
    step(1);
    lap = 1'b0;
    expect_val("pre_rst_flag", K_FLAG, fl(1, 0, 0));
    sample();
    step(22);
    #3 reset = 1'b1;
    #1;
    expect_val("arst_time", K_TIME, tp(0, 0, 0, 0));
    expect_val("arst_lap",  K_LAP,  tp(0, 0, 0, 0));
    expect_val("arst_flag", K_FLAG, fl(0, 0, 0));
    sample();
    step(2);
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/time_keeper_dp.md
Name: time_keeper_dp

Overview:
- Parametrised up/down time-keeping datapath for the stopwatch/timer product line.
- Divides `clk` down to a centisecond tick and maintains a consistent centisecond/second/minute/hour value.
- Up mode runs as a stopwatch; down mode runs as a countdown timer with preset load and a done flag.
- Adds a lap snapshot register. Sits between the control FSM (run/clear/mode/load/lap) and the display formatter.

Parameters:
- CLK_HZ, 100_000_000, input clock frequency.
- TICK_HZ, 100, base tick rate; DIV = CLK_HZ/TICK_HZ cycles per tick. DIV must be an integer ≥ 2.
- HOUR_MAX, 24, hour field modulus; HW = $clog2(HOUR_MAX).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- run  in  1  level; 1 = divider advances
- clear  in  1  level; synchronous zeroing of all state
- mode  in  1  0 = count up, 1 = count down
- load  in  1  one-cycle pulse; load preset
- pre_csec  in  7  preset centiseconds
- pre_sec  in  6  preset seconds
- pre_min  in  6  preset minutes
- pre_hour  in  HW  preset hours
- lap  in  1  one-cycle pulse; capture snapshot
- csec  out  7  0..99
- sec  out  6  0..59
- min  out  6  0..59
- hour  out  HW  0..HOUR_MAX-1
- lap_csec / lap_sec / lap_min / lap_hour  out  7/6/6/HW  snapshot fields
- lap_valid  out  1  a snapshot is held
- wrap  out  1  one-cycle pulse on up-count rollover of the whole value
- done  out  1  sticky; countdown reached zero

Behaviour:
- Reset (async): all counters, divider, lap registers, lap_valid, wrap, done = 0.
- Divider: counts 0..DIV-1 only while run=1 and not halted. Internal tick is a 1-cycle pulse on the cycle the count is DIV-1; the count then returns to 0. run=0 freezes the count and does not reset it, so a pause keeps its sub-tick phase.
- Priority per cycle: clear > load > tick.
- clear=1: divider, fields, done, wrap, lap registers and lap_valid → 0 at the next edge. load and lap are ignored that cycle.
- load=1:
  - Fields ← preset at the next edge. Any preset field ≥ its modulus saturates to modulus-1.
  - Divider ← 0; done ← 0.
  - A tick coinciding with load is discarded.
- Single-cycle carry: on a tick edge every field updates together. There is no ripple delay between fields; outputs are never transiently inconsistent.
- Up mode (mode=0):
  - csec increments. At 99 it goes to 0 and carries into sec (59→0 carries into min, 59→0 carries into hour).
  - Hour wraps HOUR_MAX-1→0.
  - wrap=1 for exactly one cycle when the value goes from all-max to all-zero.
- Down mode (mode=1):
  - csec decrements. At 0 it goes to 99 and borrows from sec (0→59 borrows from min, 0→59 borrows from hour).
  - The tick that yields 00:00:00.00 sets done=1 on the same edge.
  - While done=1 or the value is all-zero in down mode, the divider halts and ticks are ignored. No underflow is possible.
  - done clears only on clear, load or reset.
- Mode change mid-run takes effect from the next tick; the divider phase is kept. Switching to up mode releases the zero halt; done stays set.
- Lap: on a lap pulse (without clear), lap_* ← current field values (the pre-tick value if a tick coincides) and lap_valid ← 1. A later lap overwrites.
- All outputs are registered; no combinational input→output paths.

Decomposition:
- Shared package tk_pkg holds:
  - CSEC_MOD=100, SEC_MOD=60, MIN_MOD=60;
  - field widths 7/6/6;
  - typedef for the mode encoding (TK_UP=0, TK_DOWN=1).
- One sub-module, tk_field_counter, parameters MOD and W:
  - inputs en, dir, load, load_val, clr;
  - outputs val, and carry/borrow out (combinational, for the same-cycle cascade).
- Instantiate tk_field_counter four times; divider, lap and done logic stay in the top level.

Test Plan (CLK_HZ=1000, TICK_HZ=100 → DIV=10, HOUR_MAX=24):
- Reset, up mode, run=1 for 1000 cycles → csec=0, sec=1. The first tick appears 10 cycles after run rises.
- Load 23:59:59.99 in up mode, one tick → 00:00:00.00 with a single wrap pulse, all fields changing on the same edge.
- Down mode, load 00:00:01.02, run for 102 ticks → 00:00:00.00 and done=1 on that edge. A further 50 ticks leave the value at 0 and done high; a new load clears done.
- run toggled 0 for 37 cycles mid-interval → that tick interval is delayed by exactly 37 cycles.
- Lap pulse on the same cycle as a tick at 00:00:05.49 → lap_* = 00:00:05.49, lap_valid=1, live csec=50.
- Simultaneous clear+load+lap, then async reset asserted mid-count → all outputs 0, lap_valid=0, done=0.
